// File: rtl/amdc_ecs_sample_averager.sv
// Boxcar averager for eddy-current sensor X/Y samples: captures on the rising edge of the
// SPI master's done flag, averages a power-of-two window, and latches results with ready/ack.
module amdc_ecs_sample_averager #(
    parameter int DATA_W   = 18,
    parameter int MAX_LOG2 = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [2:0]        avg_log2,
    input  logic              done,
    input  logic [DATA_W-1:0] sensor_data_x,
    input  logic [DATA_W-1:0] sensor_data_y,
    input  logic              ack,
    input  logic              clr_overrun,
    output logic [DATA_W-1:0] avg_x,
    output logic [DATA_W-1:0] avg_y,
    output logic              avg_valid,
    output logic              data_ready,
    output logic              overrun,
    output logic [15:0]       sample_count
);
    localparam int ACC_W = DATA_W + MAX_LOG2;
    localparam int CNT_W = MAX_LOG2 + 1;

    // state  | meaning
    // S_IDLE | averaging disabled, window state held cleared
    // S_ACC  | accumulating samples of the current window
    // S_DUMP | window complete, latch the shifted sums (one cycle)
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DUMP} state_t;

    state_t                  state, state_nxt;
    logic                    done_d, smp_vld;
    logic [DATA_W-1:0]       smp_x, smp_y;
    logic signed [ACC_W-1:0] acc_x, acc_y;
    logic [CNT_W-1:0]        win_cnt;
    logic [2:0]              n_lat;

    logic                    smp_take, acc_add, acc_clr, dump, win_last;
    logic [2:0]              win_log2;
    logic [CNT_W-1:0]        win_size;
    logic signed [ACC_W-1:0] ext_x, ext_y, shf_x, shf_y;

    assign smp_take = done & ~done_d & enable;
    // The exponent is only sampled on the first sample of a window; later changes wait.
    assign win_log2 = (win_cnt == '0) ? avg_log2 : n_lat;
    assign win_size = CNT_W'(1) << win_log2;
    assign win_last = (win_cnt + CNT_W'(1)) == win_size;
    assign ext_x    = {{MAX_LOG2{smp_x[DATA_W-1]}}, smp_x};
    assign ext_y    = {{MAX_LOG2{smp_y[DATA_W-1]}}, smp_y};
    assign shf_x    = acc_x >>> n_lat;
    assign shf_y    = acc_y >>> n_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_add   = 1'b0;
        acc_clr   = 1'b0;
        dump      = 1'b0;
        unique case (state)
            S_IDLE: begin
                acc_clr = 1'b1;
                if (enable) state_nxt = S_ACC;
            end
            S_ACC: begin
                if (!enable) begin
                    acc_clr   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (smp_vld) begin
                    acc_add = 1'b1;
                    if (win_last) state_nxt = S_DUMP;
                end
            end
            S_DUMP: begin
                dump      = 1'b1;
                acc_clr   = 1'b1;
                state_nxt = enable ? S_ACC : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_d       <= 1'b0;
            smp_vld      <= 1'b0;
            smp_x        <= '0;
            smp_y        <= '0;
            sample_count <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            win_cnt      <= '0;
            n_lat        <= '0;
            avg_x        <= '0;
            avg_y        <= '0;
            avg_valid    <= 1'b0;
            data_ready   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            done_d <= done;

            if (smp_take) begin
                smp_x        <= sensor_data_x;
                smp_y        <= sensor_data_y;
                smp_vld      <= 1'b1;
                sample_count <= sample_count + 16'd1;
            end else if (acc_add || !enable) begin
                smp_vld <= 1'b0;
            end

            if (acc_clr) begin
                acc_x   <= '0;
                acc_y   <= '0;
                win_cnt <= '0;
            end else if (acc_add) begin
                acc_x   <= acc_x + ext_x;
                acc_y   <= acc_y + ext_y;
                win_cnt <= win_cnt + CNT_W'(1);
                if (win_cnt == '0) n_lat <= avg_log2;
            end

            avg_valid <= dump;
            if (dump) begin
                avg_x <= shf_x[DATA_W-1:0];
                avg_y <= shf_y[DATA_W-1:0];
            end

            // A fresh result keeps data_ready high even if the reader acks in the same cycle.
            if (dump)     data_ready <= 1'b1;
            else if (ack) data_ready <= 1'b0;

            if (dump && data_ready && !ack) overrun <= 1'b1;
            else if (clr_overrun)           overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_amdc_ecs_sample_averager.sv
// Scoreboard bench for the sample averager: a window-level reference model predicts each
// latched average and handshake state; a monitor compares them as avg_valid pulses appear.
module tb_amdc_ecs_sample_averager;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          done = 1'b0;
    logic          ack = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [2:0]    avg_log2 = 3'd0;
    logic [DW-1:0] sensor_data_x = '0;
    logic [DW-1:0] sensor_data_y = '0;
    logic [DW-1:0] avg_x, avg_y;
    logic          avg_valid, data_ready, overrun;
    logic [15:0]   sample_count;

    amdc_ecs_sample_averager #(.DATA_W(DW), .MAX_LOG2(7)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .avg_log2(avg_log2), .done(done),
        .sensor_data_x(sensor_data_x), .sensor_data_y(sensor_data_y), .ack(ack),
        .clr_overrun(clr_overrun), .avg_x(avg_x), .avg_y(avg_y), .avg_valid(avg_valid),
        .data_ready(data_ready), .overrun(overrun), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic          rdy;
        logic          ovr;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   win_x[$];
    int   win_y[$];
    int   win_n = 1;
    int   m_count = 0;
    bit   m_ready = 0;
    bit   m_ovr = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_valid = 0;
    int   v0, c0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int floor_div(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic void model_step(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                       input bit ack_d, input bit clr_d, input bit en);
        logic signed [DW-1:0] sx, sy;
        int   sum_x, sum_y;
        logic [31:0] qx, qy;
        exp_t e;
        bit   fire;
        fire = 0;
        if (en) begin
            m_count = (m_count + 1) % 65536;
            sx = x;
            sy = y;
            win_x.push_back(int'(sx));
            win_y.push_back(int'(sy));
            if (win_x.size() == 1) win_n = 1 << avg_log2;
            if (win_x.size() == win_n) begin
                sum_x = 0;
                sum_y = 0;
                foreach (win_x[i]) begin
                    sum_x += win_x[i];
                    sum_y += win_y[i];
                end
                qx = floor_div(sum_x, win_n);
                qy = floor_div(sum_y, win_n);
                win_x.delete();
                win_y.delete();
                fire = 1;
                if (m_ready && !ack_d) m_ovr = 1;
                else if (clr_d)        m_ovr = 0;
                m_ready = 1;
                e.x   = qx[DW-1:0];
                e.y   = qy[DW-1:0];
                e.rdy = 1'b1;
                e.ovr = m_ovr;
                e.cyc = cyc;
                exp_q.push_back(e);
            end
        end
        if (!fire) begin
            if (ack_d) m_ready = 0;
            if (clr_d) m_ovr = 0;
        end
    endfunction

    // done rises at n0; ack/clr are presented in the cycle that ends with the latch edge.
    task automatic send_sample(input logic [DW-1:0] x, input logic [DW-1:0] y,
                               input bit ack_d, input bit clr_d);
        @(negedge clk);
        done = 1'b1;
        sensor_data_x = x;
        sensor_data_y = y;
        model_step(x, y, ack_d, clr_d, enable);
        @(negedge clk);
        @(negedge clk);
        ack = ack_d;
        clr_overrun = clr_d;
        @(negedge clk);
        ack = 1'b0;
        clr_overrun = 1'b0;
        @(negedge clk);
        done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        m_ready = 0;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr_overrun = 1'b1;
        m_ovr = 0;
        @(negedge clk);
        clr_overrun = 1'b0;
    endtask

    task automatic set_enable(input bit v);
        @(negedge clk);
        enable = v;
        if (!v) begin
            win_x.delete();
            win_y.delete();
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (avg_valid === 1'b1) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_avg_valid: got avg_x=0x%0h avg_y=0x%0h, expected no result",
                             avg_x, avg_y);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("avg_x", int'(avg_x), int'(mon_e.x));
                    check("avg_y", int'(avg_y), int'(mon_e.y));
                    check("data_ready_on_valid", int'(data_ready), int'(mon_e.rdy));
                    check("overrun_on_valid", int'(overrun), int'(mon_e.ovr));
                    check("latency", cyc - mon_e.cyc, 3);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_avg_x", int'(avg_x), 0);
        check("reset_flags", int'({avg_valid, data_ready, overrun}), 0);
        check("reset_sample_count", int'(sample_count), 0);
        rst_n = 1'b1;
        set_enable(1);

        // Window of 4: floor averaging on both channels
        avg_log2 = 3'd2;
        send_sample(18'd10, 18'h3FFFF, 0, 0);
        send_sample(18'd20, 18'h3FFFF, 0, 0);
        send_sample(18'd30, 18'h3FFFF, 0, 0);
        send_sample(18'd41, 18'h3FFFE, 0, 0);
        check("win4_avg_x", int'(avg_x), 25);
        check("win4_avg_y", int'(avg_y), 'h3FFFE);
        check("win4_valid_count", n_valid, 1);
        check("win4_data_ready", int'(data_ready), 1);

        // Reset in the middle of a window
        send_sample(18'd7, 18'd7, 0, 0);
        send_sample(18'd9, 18'd9, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_avg_x", int'(avg_x), 0);
        check("midrst_avg_y", int'(avg_y), 0);
        check("midrst_flags", int'({avg_valid, data_ready, overrun}), 0);
        check("midrst_sample_count", int'(sample_count), 0);
        win_x.delete();
        win_y.delete();
        m_count = 0;
        m_ready = 0;
        m_ovr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        avg_log2 = 3'd0;
        send_sample(18'h1FFFF, 18'h00005, 0, 0);
        check("postrst_passthru_x", int'(avg_x), 'h1FFFF);
        check("postrst_passthru_y", int'(avg_y), 5);
        do_ack();

        // Full-scale windows of 128
        avg_log2 = 3'd7;
        for (int i = 0; i < 128; i++) send_sample(18'h1FFFF, 18'h20000, 0, 0);
        check("fs_pos_x", int'(avg_x), 'h1FFFF);
        check("fs_neg_y", int'(avg_y), 'h20000);
        do_ack();
        for (int i = 0; i < 128; i++) send_sample(18'h20000, 18'h1FFFF, 0, 0);
        check("fs_neg_x", int'(avg_x), 'h20000);
        check("fs_pos_y", int'(avg_y), 'h1FFFF);
        do_ack();

        // Exponent change inside a window applies from the next window
        avg_log2 = 3'd1;
        v0 = n_valid;
        send_sample(18'd4, 18'd0, 0, 0);
        avg_log2 = 3'd3;
        send_sample(18'd6, 18'd0, 0, 0);
        check("midchg_first_window", n_valid - v0, 1);
        check("midchg_first_avg", int'(avg_x), 5);
        for (int i = 0; i < 7; i++) send_sample(18'd16, 18'd0, 0, 0);
        check("midchg_second_pending", n_valid - v0, 1);
        send_sample(18'd24, 18'd0, 0, 0);
        check("midchg_second_window", n_valid - v0, 2);
        check("midchg_second_avg", int'(avg_x), 17);

        // Handshake: overrun, coincident ack, clear versus set
        avg_log2 = 3'd0;
        do_ack();
        do_clr();
        send_sample(18'd1, 18'd1, 0, 0);
        send_sample(18'd2, 18'd2, 0, 0);
        check("hs_overrun_set", int'(overrun), 1);
        check("hs_ready_set", int'(data_ready), 1);
        send_sample(18'd3, 18'd3, 1, 0);
        check("hs_coinc_ack_ready", int'(data_ready), 1);
        check("hs_coinc_ack_ovr", int'(overrun), 1);
        do_clr();
        check("hs_clr", int'(overrun), 0);
        send_sample(18'd4, 18'd4, 1, 0);
        check("hs_coinc_ack_no_ovr", int'(overrun), 0);
        send_sample(18'd5, 18'd5, 0, 1);
        check("hs_set_beats_clr", int'(overrun), 1);
        do_ack();
        check("hs_ack_clears", int'(data_ready), 0);

        // Enable drop discards the partial window and samples taken while disabled
        do_clr();
        avg_log2 = 3'd2;
        c0 = int'(sample_count);
        v0 = n_valid;
        for (int i = 0; i < 3; i++) send_sample(18'd100, 18'd100, 0, 0);
        set_enable(0);
        send_sample(18'd500, 18'd500, 0, 0);
        set_enable(1);
        for (int i = 0; i < 4; i++) send_sample(18'd8, 18'h3FFF8, 0, 0);
        check("endrop_avg_x", int'(avg_x), 8);
        check("endrop_avg_y", int'(avg_y), 'h3FFF8);
        check("endrop_valid_count", n_valid - v0, 1);
        check("endrop_sample_count", int'(sample_count) - c0, 7);

        // Randomized windows, exponents, handshakes and enable drops
        for (int i = 0; i < 60; i++) begin
            logic [DW-1:0] rx, ry;
            if ($urandom_range(0, 3) == 0) avg_log2 = 3'($urandom_range(0, 3));
            rx = DW'($urandom);
            ry = DW'($urandom);
            if ($urandom_range(0, 11) == 0) begin
                set_enable(0);
                send_sample(rx, ry, 0, 0);
                set_enable(1);
            end else begin
                send_sample(rx, ry, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            end
            if ($urandom_range(0, 5) == 0) do_ack();
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_sample_count", int'(sample_count), m_count);
        check("final_data_ready", int'(data_ready), int'(m_ready));
        check("final_overrun", int'(overrun), int'(m_ovr));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
